// File: rtl/fp_norm_round_pipe.sv
// Three-stage normalise-and-round pipeline for the FP adder datapath (valid/ready, full backpressure).
// Define FP_NORM_DIRECTED_ROUND_EN to honour in_rmode; without it the block rounds RNE only.
module fp_norm_round_pipe #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sign,
    input  logic signed [EXP_WIDTH+1:0]   in_exp,
    input  logic [FRAC_WIDTH+4:0]         in_mant,
    input  logic [1:0]                    in_rmode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [EXP_WIDTH+FRAC_WIDTH:0] out_result,
    output logic [2:0]                    out_flags
);
    localparam int MW  = FRAC_WIDTH + 5;
    localparam int XW  = EXP_WIDTH + 3;
    localparam int LZW = $clog2(MW + 1);
    localparam int RW  = EXP_WIDTH + FRAC_WIDTH + 1;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    function automatic logic [LZW-1:0] count_lz(input logic [MW-1:0] m);
        logic [LZW-1:0] n;
        n = LZW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (m[i]) n = LZW'(MW - 1 - i);
        end
        return n;
    endfunction

    function automatic logic round_inc(input logic [1:0] rm, input logic s, input logic l,
                                       input logic g, input logic r, input logic st);
        logic inc;
        case (rm)
            RM_RNE:  inc = g & (r | st | l);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = ~s & (g | r | st);
            default: inc = s & (g | r | st);
        endcase
        return inc;
    endfunction

    function automatic logic ovf_to_inf(input logic [1:0] rm, input logic s);
        return (rm == RM_RNE) || ((rm == RM_RUP) && !s) || ((rm == RM_RDN) && s);
    endfunction

    function automatic logic [RW-1:0] sat_result(input logic s, input logic to_inf);
        if (to_inf) return {s, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
        return {s, {(EXP_WIDTH-1){1'b1}}, 1'b0, {FRAC_WIDTH{1'b1}}};
    endfunction

    logic vld_p0_q, vld_p1_q, vld_p2_q;
    logic vld_p0_d, vld_p1_d, vld_p2_d;
    logic adv_p1, adv_p2;

    // each stage loads when it is empty or its successor is loading this cycle
    assign adv_p2   = ~vld_p2_q | out_ready;
    assign adv_p1   = ~vld_p1_q | adv_p2;
    assign in_ready = ~vld_p0_q | adv_p1;

    always_comb begin
        vld_p0_d = in_ready ? in_valid : vld_p0_q;
        vld_p1_d = adv_p1   ? vld_p0_q : vld_p1_q;
        vld_p2_d = adv_p2   ? vld_p1_q : vld_p2_q;
    end

    // ---- stage 1: capture triple and leading-zero count
    logic                        sign_p0_q, sign_p0_d;
    logic signed [EXP_WIDTH+1:0] exp_p0_q, exp_p0_d;
    logic [MW-1:0]               mant_p0_q, mant_p0_d;
    logic [LZW-1:0]              lz_p0_q, lz_p0_d;

    always_comb begin
        sign_p0_d = in_ready ? in_sign : sign_p0_q;
        exp_p0_d  = in_ready ? in_exp : exp_p0_q;
        mant_p0_d = in_ready ? in_mant : mant_p0_q;
        lz_p0_d   = in_ready ? count_lz(in_mant) : lz_p0_q;
    end

    logic [1:0] rm_p1;
`ifdef FP_NORM_DIRECTED_ROUND_EN
    logic [1:0] rm_p0_q, rm_p0_d, rm_p1_q, rm_p1_d;

    always_comb begin
        rm_p0_d = in_ready ? in_rmode : rm_p0_q;
        rm_p1_d = adv_p1   ? rm_p0_q  : rm_p1_q;
    end

    always_ff @(posedge clk) begin
        rm_p0_q <= rm_p0_d;
        rm_p1_q <= rm_p1_d;
    end

    assign rm_p1 = rm_p1_q;
`else
    logic unused_rmode;
    assign unused_rmode = ^in_rmode;
    assign rm_p1        = RM_RNE;
`endif

    // ---- stage 2: normalise; la>0 shifts left, la<0 shifts right into sticky
    logic signed [XW-1:0] lsh, emax, la, rsh;
    logic signed [XW-1:0] e_p1_q, e_p1_d;
    logic [LZW-1:0]       r_amt;
    logic [MW:0]          wrk, shl, shr, lost_mask;
    logic [MW-1:0]        nm;
    logic [MW-1:0]        nm_p1_q, nm_p1_d;
    logic                 sign_p1_q, sign_p1_d, zero_p1_q, zero_p1_d;

    always_comb begin
        wrk       = {mant_p0_q, 1'b0};
        lsh       = $signed(XW'(lz_p0_q)) - XW'(1);
        emax      = XW'(exp_p0_q) - XW'(1);
        la        = (lsh < emax) ? lsh : emax;
        rsh       = -la;
        r_amt     = (rsh > XW'(MW)) ? LZW'(MW) : rsh[LZW-1:0];
        shl       = wrk << la[LZW-1:0];
        shr       = wrk >> r_amt;
        lost_mask = ~({(MW+1){1'b1}} << r_amt);
        nm        = la[XW-1] ? {shr[MW:2], shr[1] | shr[0] | (|(wrk & lost_mask))}
                             : shl[MW:1];
        sign_p1_d = adv_p1 ? sign_p0_q : sign_p1_q;
        zero_p1_d = adv_p1 ? (lz_p0_q == LZW'(MW)) : zero_p1_q;
        nm_p1_d   = adv_p1 ? nm : nm_p1_q;
        e_p1_d    = adv_p1 ? (XW'(exp_p0_q) - la) : e_p1_q;
    end

    logic unused_bits;
    assign unused_bits = shl[0] ^ nm_p1_q[MW-1];

    // ---- stage 3: round, renormalise on carry, detect overflow/underflow
    logic                   l_b, g_b, r_b, s_b, inc, inx, ovf;
    logic [FRAC_WIDTH+1:0]  sum;
    logic signed [XW-1:0]   e_fin;
    logic [FRAC_WIDTH-1:0]  frac_fin;
    logic [RW-1:0]          res_p2_q, res_p2_d;
    logic [2:0]             flg_p2_q, flg_p2_d;

    always_comb begin
        l_b = nm_p1_q[3];
        g_b = nm_p1_q[2];
        r_b = nm_p1_q[1];
        s_b = nm_p1_q[0];
        inc = round_inc(rm_p1, sign_p1_q, l_b, g_b, r_b, s_b);
        inx = g_b | r_b | s_b;
        sum = {1'b0, nm_p1_q[MW-2:3]} + (FRAC_WIDTH+2)'(inc);
        if (sum[FRAC_WIDTH+1]) begin
            e_fin    = e_p1_q + XW'(1);
            frac_fin = '0;
        end else if (sum[FRAC_WIDTH]) begin
            e_fin    = e_p1_q;
            frac_fin = sum[FRAC_WIDTH-1:0];
        end else begin
            e_fin    = '0;
            frac_fin = sum[FRAC_WIDTH-1:0];
        end
        ovf      = e_fin >= XW'((1 << EXP_WIDTH) - 1);
        res_p2_d = res_p2_q;
        flg_p2_d = flg_p2_q;
        if (adv_p2) begin
            if (zero_p1_q) begin
                res_p2_d = {sign_p1_q, {(RW-1){1'b0}}};
                flg_p2_d = 3'b000;
            end else if (ovf) begin
                res_p2_d = sat_result(sign_p1_q, ovf_to_inf(rm_p1, sign_p1_q));
                flg_p2_d = 3'b101;
            end else begin
                res_p2_d = {sign_p1_q, e_fin[EXP_WIDTH-1:0], frac_fin};
                flg_p2_d = {1'b0, inx & (e_fin == '0), inx};
            end
        end
    end

    always_ff @(posedge clk) begin
        sign_p0_q <= sign_p0_d;
        exp_p0_q  <= exp_p0_d;
        mant_p0_q <= mant_p0_d;
        lz_p0_q   <= lz_p0_d;
        sign_p1_q <= sign_p1_d;
        zero_p1_q <= zero_p1_d;
        nm_p1_q   <= nm_p1_d;
        e_p1_q    <= e_p1_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            res_p2_q <= '0;
            flg_p2_q <= '0;
        end else begin
            vld_p0_q <= vld_p0_d;
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            res_p2_q <= res_p2_d;
            flg_p2_q <= flg_p2_d;
        end
    end

    assign out_valid  = vld_p2_q;
    assign out_result = res_p2_q;
    assign out_flags  = flg_p2_q;

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Directed bench for fp_norm_round_pipe: rounding/overflow/subnormal vectors, backpressure, reset mid-stream.
module tb_fp_norm_round_pipe;
`ifdef FP_NORM_DIRECTED_ROUND_EN
    localparam bit DIR = 1'b1;
`else
    localparam bit DIR = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid, in_ready, in_sign;
    logic signed [9:0]  in_exp;
    logic [27:0]        in_mant;
    logic [1:0]         in_rmode;
    logic               out_valid, out_ready;
    logic [31:0]        out_result;
    logic [2:0]         out_flags;
    int                 n_chk = 0;
    int                 n_err = 0;

    always #5 clk = ~clk;

    fp_norm_round_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_rmode   (in_rmode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    task automatic send_one(input string tag, input logic s, input logic [9:0] e,
                            input logic [27:0] m, input logic [1:0] rm,
                            input logic [31:0] er, input logic [2:0] ef);
        int lat;
        @(negedge clk);
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_rmode = rm;
        in_valid = 1'b1;
        #1;
        chk({tag, "_rdy"}, 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        in_rmode = ~rm;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(3));
        chk({tag, "_res"}, 64'(out_result), 64'(er));
        chk({tag, "_flg"}, 64'(out_flags), 64'(ef));
    endtask

    task automatic run_vectors();
        send_one("carry",     1'b0, 10'd127, 28'hC000000, 2'b00, 32'h40400000, 3'b000);
        send_one("tie_l0",    1'b0, 10'd127, 28'h4000004, 2'b00, 32'h3F800000, 3'b001);
        send_one("tie_l1",    1'b0, 10'd127, 28'h400000C, 2'b00, 32'h3F800002, 3'b001);
        send_one("rup_l0",    1'b0, 10'd127, 28'h4000004, 2'b10,
                 DIR ? 32'h3F800001 : 32'h3F800000, 3'b001);
        send_one("rup_l1",    1'b0, 10'd127, 28'h400000C, 2'b10, 32'h3F800002, 3'b001);
        send_one("rdn_neg",   1'b1, 10'd127, 28'h4000004, 2'b11,
                 DIR ? 32'hBF800001 : 32'hBF800000, 3'b001);
        send_one("ovf_rne",   1'b0, 10'd254, 28'h8000000, 2'b00, 32'h7F800000, 3'b101);
        send_one("ovf_rtz",   1'b0, 10'd254, 28'h8000000, 2'b01,
                 DIR ? 32'h7F7FFFFF : 32'h7F800000, 3'b101);
        send_one("ovf_nrup",  1'b1, 10'd254, 28'h8000000, 2'b10,
                 DIR ? 32'hFF7FFFFF : 32'hFF800000, 3'b101);
        send_one("cancel",    1'b0, 10'd127, 28'h0000008, 2'b00, 32'h34000000, 3'b000);
        send_one("subn",      1'b0, 10'd2,   28'h0000008, 2'b00, 32'h00000002, 3'b000);
        send_one("subn_inx",  1'b0, 10'd2,   28'h0000009, 2'b00, 32'h00000002, 3'b011);
        send_one("neg_zero",  1'b1, 10'd127, 28'h0000000, 2'b00, 32'h80000000, 3'b000);
        send_one("subn_norm", 1'b0, 10'd0,   28'h7FFFFF8, 2'b00, 32'h00800000, 3'b001);
        send_one("rnd_carry", 1'b0, 10'd127, 28'h7FFFFFE, 2'b00, 32'h40000000, 3'b001);
        send_one("deep_subn", 1'b0, 10'h39C, 28'h4000000, 2'b10,
                 DIR ? 32'h00000001 : 32'h00000000, 3'b011);
    endtask

    task automatic run_backpressure();
        int          idx;
        int          npop;
        logic [31:0] held;
        logic [31:0] got_r[6];
        int          got_c[6];
        idx  = 0;
        npop = 0;
        held = '0;
        for (int k = 0; k < 6; k++) begin
            got_r[k] = '0;
            got_c[k] = -1;
        end
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c <= 9);
            if (idx < 6) begin
                in_valid = 1'b1;
                in_sign  = 1'b0;
                in_exp   = 10'sd127;
                in_mant  = 28'(32'h4000000 | ((idx + 1) << 3));
                in_rmode = 2'b00;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 4) begin
                chk("bp_rdy_low", 64'(in_ready), 64'(0));
                chk("bp_accepted", 64'(idx), 64'(4));
                held = out_result;
            end
            if (c >= 5 && c <= 9) begin
                chk("bp_stall_vld", 64'(out_valid), 64'(1));
                chk("bp_stall_res", 64'(out_result), 64'(held));
            end
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready && npop < 6) begin
                got_r[npop] = out_result;
                got_c[npop] = c;
                npop++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 64'(npop), 64'(6));
        for (int k = 0; k < 6; k++) begin
            chk("bp_data", 64'(got_r[k]), 64'(32'h3F800000 + 32'(k + 1)));
            chk("bp_cycle", 64'(got_c[k]), 64'((k == 0) ? 3 : 9 + k));
        end
    endtask

    task automatic run_reset_midstream();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sign  = 1'b0;
            in_exp   = 10'sd127;
            in_mant  = 28'(32'h4000000 | ((k + 9) << 3));
            in_rmode = 2'b00;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("rst_pre_vld", 64'(out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_vld", 64'(out_valid), 64'(0));
        chk("rst_async_res", 64'(out_result), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_rdy", 64'(in_ready), 64'(1));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("rst_no_stale", 64'(out_valid), 64'(0));
        end
        send_one("post_rst", 1'b0, 10'd127, 28'hC000000, 2'b00, 32'h40400000, 3'b000);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        in_rmode  = 2'b00;
        out_ready = 1'b1;
        #1;
        chk("rst_vld", 64'(out_valid), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init_vld", 64'(out_valid), 64'(0));
        chk("init_res", 64'(out_result), 64'(0));
        chk("init_flg", 64'(out_flags), 64'(0));
        chk("init_rdy", 64'(in_ready), 64'(1));
        run_vectors();
        run_backpressure();
        run_reset_midstream();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
